pipe_hazard_ctrl: RTL

Hazard and sequencing controller for the 5-stage pipelined CPU (IF/ID/EX/M/W). It generates the PC/IF-ID stall, the IF/ID and ID/EX flushes, and the EX-stage operand forwarding selects. It also sequences the switch-input read instruction: the pipeline is held until a debounced button press, which shares the single user button between the program and the core. A saturating stall counter is exposed for debug LEDs.

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_hazard_ctrl                                                |
// | Purpose  : Stall/flush/forwarding control and switch-input sequencing for  |
// |            the 5-stage pipeline, with a debounced shared user button.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           ID_rs1,
    input  logic [4:0]           ID_rs2,
    input  logic                 ID_UsesRs1,
    input  logic                 ID_UsesRs2,
    input  logic                 ID_IOWait,
    input  logic [4:0]           EX_rs1,
    input  logic [4:0]           EX_rs2,
    input  logic [4:0]           EX_WriteReg,
    input  logic                 EX_RegWrite,
    input  logic                 EX_MemtoReg,
    input  logic                 EX_PCsel,
    input  logic [4:0]           M_WriteReg,
    input  logic                 M_RegWrite,
    input  logic [4:0]           W_rd,
    input  logic                 W_RegWrite,
    input  logic                 button,
    output logic                 stall,
    output logic                 flushID,
    output logic                 flushEX,
    output logic [1:0]           forward1,
    output logic [1:0]           forward2,
    output logic                 io_ack,
    output logic                 io_busy,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int                c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_W-1:0] c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_S_RUN     = 2'd0;
    localparam logic [1:0] c_S_IO_WAIT = 2'd1;
    localparam logic [1:0] c_S_IO_ACK  = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [c_DB_W-1:0]    r_db_cnt;
    logic                 r_db_level;
    logic                 r_db_prev;
    logic                 w_press;
    logic                 w_load_use;
    logic                 w_rs1_hit;
    logic                 w_rs2_hit;
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Forwarding: the younger M result wins over W.
    always_comb begin
        forward1 = 2'd0;
        if (M_RegWrite && (M_WriteReg != 5'd0) && (M_WriteReg == EX_rs1))
            forward1 = 2'd1;
        else if (W_RegWrite && (W_rd != 5'd0) && (W_rd == EX_rs1))
            forward1 = 2'd2;
    end

    always_comb begin
        forward2 = 2'd0;
        if (M_RegWrite && (M_WriteReg != 5'd0) && (M_WriteReg == EX_rs2))
            forward2 = 2'd1;
        else if (W_RegWrite && (W_rd != 5'd0) && (W_rd == EX_rs2))
            forward2 = 2'd2;
    end

    assign w_rs1_hit  = ID_UsesRs1 && (ID_rs1 == EX_WriteReg);
    assign w_rs2_hit  = ID_UsesRs2 && (ID_rs2 == EX_WriteReg);
    assign w_load_use = EX_MemtoReg && EX_RegWrite && (EX_WriteReg != 5'd0)
                        && (w_rs1_hit || w_rs2_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_db_prev <= r_db_level;
            if (button == r_db_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_MAX) begin
                r_db_cnt   <= '0;
                r_db_level <= button;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_db_level && !r_db_prev;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_S_RUN;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        flushID      = 1'b0;
        flushEX      = 1'b0;
        io_ack       = 1'b0;
        io_busy      = 1'b0;
        if (rst) begin
            w_state_next = c_S_RUN;
        end else if (EX_PCsel) begin
            // A taken branch squashes any pending switch read without acknowledging it.
            flushID      = 1'b1;
            flushEX      = 1'b1;
            w_state_next = c_S_RUN;
        end else begin
            case (r_state)
                c_S_IO_WAIT: begin
                    stall   = 1'b1;
                    flushEX = 1'b1;
                    io_busy = 1'b1;
                    if (w_press) w_state_next = c_S_IO_ACK;
                end
                c_S_IO_ACK: begin
                    io_ack       = 1'b1;
                    w_state_next = c_S_RUN;
                end
                default: begin
                    if (w_load_use) begin
                        stall   = 1'b1;
                        flushEX = 1'b1;
                    end else if (ID_IOWait) begin
                        w_state_next = c_S_IO_WAIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                       r_stall_cnt <= '0;
        else if (stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign stall_count = r_stall_cnt;

endmodule
`default_nettype wire
